sv_im_banked: RTL and testbench

//  Parametrised double-bank instruction memory for the EC scalar-multiply/sign microcoded core.

---
 rtl/sv_im_pkg.sv | 57 +++++
 rtl/sv_im_rom.sv | 28 ++
 rtl/sv_im_banked.sv | 233 +++++++++++++++++++++++
 tb/tb_sv_im_banked.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sv_im_pkg.sv
// ---------------------------------------------------------------------------
// sv_im_pkg
// Shared definitions for the banked instruction memory of the EC
// scalar-multiply/sign microcoded core.
//   - instruction field layout: {src_b[15:12], src_a[11:8], dst[7:4], op[3:0]}
//   - opcode constants and the END instruction
//   - controller state enum (INIT = boot copy, RUN = normal operation)
//   - default microcode program table read by sv_im_rom
//   - even-parity helper used when SV_IM_PARITY_EN is defined
// ---------------------------------------------------------------------------
package sv_im_pkg;

  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_END = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_MUL = 4'h6;
  localparam logic [3:0] OP_SQR = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_BIT = 4'h9;

  localparam logic [15:0] SV_IM_END_INSTR = {12'h000, OP_END};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sv_im_state_e;

  // Default program; every address past the table reads as END.
  localparam int SV_IM_PROG_LEN = 16;
  localparam int SV_IM_PROG_AW  = 4;
  localparam logic [15:0] SV_IM_PROG [SV_IM_PROG_LEN] = '{
    {4'h0, 4'h0, 4'h1, OP_LD },
    {4'h0, 4'h1, 4'h2, OP_LD },
    {4'h0, 4'h2, 4'h3, OP_LD },
    {4'h0, 4'h0, 4'h4, OP_BIT},
    {4'h2, 4'h1, 4'h4, OP_SQR},
    {4'h3, 4'h2, 4'h4, OP_MUL},
    {4'h2, 4'h1, 4'h5, OP_SUB},
    {4'h0, 4'h3, 4'h0, OP_JMP},
    {4'h1, 4'h4, 4'h2, OP_ADD},
    {4'h0, 4'h5, 4'h1, OP_ST },
    {4'h4, 4'h4, 4'h0, OP_MUL},
    {4'h5, 4'h6, 4'h1, OP_SQR},
    {4'h0, 4'h7, 4'h5, OP_JMP},
    {4'h6, 4'h6, 4'h0, OP_ADD},
    {4'h0, 4'h8, 4'h6, OP_ST },
    {4'h0, 4'h9, 4'h0, OP_ST }
  };

  // Even parity over a zero-extended word (zero padding does not change it).
  function automatic logic sv_im_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sv_im_rom.sv
// ---------------------------------------------------------------------------
// sv_im_rom
// Combinational default microcode ROM used for the boot copy into bank 0.
// Ports:
//   addr_i  in  AW  word address
//   word_o  out IW  program word, END instruction beyond the program
// ---------------------------------------------------------------------------
module sv_im_rom
  import sv_im_pkg::*;
#(
  parameter int IW = 16,
  parameter int AW = 8
) (
  input  logic [AW-1:0] addr_i,
  output logic [IW-1:0] word_o
);

  // Program table lookup with END fill past the last programmed word.
  always_comb begin
    word_o = IW'(SV_IM_END_INSTR);
    if ({1'b0, addr_i} < (AW+1)'(SV_IM_PROG_LEN)) begin
      word_o = IW'(SV_IM_PROG[addr_i[SV_IM_PROG_AW-1:0]]);
    end else begin
      word_o = IW'(SV_IM_END_INSTR);
    end
  end

endmodule

// File: rtl/sv_im_banked.sv
// ---------------------------------------------------------------------------
// sv_im_banked
// Double-bank instruction memory. The core fetches from the active bank while
// the host writes new microcode into the shadow bank; a swap request flips
// the banks at the first cycle without a fetch. After reset bank 0 is loaded
// from sv_im_rom one word per cycle before ready_o rises.
// Optional feature: define SV_IM_PARITY_EN to store an even-parity bit per
// word and flag mismatches on fetch (par_err_o tied 0 otherwise).
// Ports:
//   clk, areset            clock, asynchronous active-high reset
//   iaddr_i, ivalid_i      fetch request
//   instr_o, ivalid_o      fetch result, one cycle after the request
//   ready_o                boot copy finished
//   upd_valid_i/ready_o    shadow-bank write handshake (addr/data inputs)
//   upd_err_o              pulse after an accepted out-of-range update
//   swap_req_i/swap_ack_o  bank swap request / firing-cycle acknowledge
//   active_bank_o          bank currently fetched from
//   par_err_o              parity mismatch on the returned fetch
// ---------------------------------------------------------------------------
module sv_im_banked
  import sv_im_pkg::*;
#(
  parameter int IW    = 16,
  parameter int AW    = 8,
  parameter int DEPTH = 128
) (
  input  logic          clk,
  input  logic          areset,
  input  logic [AW-1:0] iaddr_i,
  input  logic          ivalid_i,
  output logic [IW-1:0] instr_o,
  output logic          ivalid_o,
  output logic          ready_o,
  input  logic          upd_valid_i,
  output logic          upd_ready_o,
  input  logic [AW-1:0] upd_addr_i,
  input  logic [IW-1:0] upd_data_i,
  output logic          upd_err_o,
  input  logic          swap_req_i,
  output logic          swap_ack_o,
  output logic          active_bank_o,
  output logic          par_err_o
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SV_IM_PARITY_EN
  localparam int SW = IW + 1;
`else
  localparam int SW = IW;
`endif

  // Encode a data word for storage (parity bit on top when enabled).
  function automatic logic [SW-1:0] store_word(input logic [IW-1:0] d);
`ifdef SV_IM_PARITY_EN
    return {sv_im_parity(64'(d)), d};
`else
    return d;
`endif
  endfunction

  logic [SW-1:0] bank0_q [DEPTH];
  logic [SW-1:0] bank1_q [DEPTH];

  sv_im_state_e  state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          pending_q, pending_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          ivalid_q, ivalid_d;
  logic          upd_err_q, upd_err_d;
  logic          par_err_q, par_err_d;

  logic [IW-1:0]   rom_word_s;
  logic [SW-1:0]   rd_word_s;
  logic            par_bad_s;
  logic            iaddr_ok_s;
  logic            upd_ok_s;
  logic            swap_fire_s;
  logic            upd_ready_s;
  logic            we0_s, we1_s;
  logic [IDXW-1:0] wa0_s, wa1_s;
  logic [SW-1:0]   wd0_s, wd1_s;

  sv_im_rom #(.IW(IW), .AW(AW)) u_rom (
    .addr_i (cnt_q),
    .word_o (rom_word_s)
  );

  assign iaddr_ok_s = ({1'b0, iaddr_i} < (AW+1)'(DEPTH));
  assign upd_ok_s   = ({1'b0, upd_addr_i} < (AW+1)'(DEPTH));
  // Out-of-range addresses may index past the array; the result is masked.
  assign rd_word_s  = active_q ? bank1_q[iaddr_i[IDXW-1:0]]
                               : bank0_q[iaddr_i[IDXW-1:0]];

  // Parity check of the stored word on the fetch path.
  always_comb begin
    par_bad_s = 1'b0;
`ifdef SV_IM_PARITY_EN
    par_bad_s = sv_im_parity(64'(rd_word_s));
`else
    par_bad_s = 1'b0;
`endif
  end

  // Swap fires in the request cycle or later, only in a cycle without a
  // fetch; the update port is closed in that cycle so no write races the flip.
  always_comb begin
    swap_fire_s = 1'b0;
    upd_ready_s = 1'b0;
    if (state_q == ST_RUN) begin
      swap_fire_s = (pending_q | swap_req_i) & ~ivalid_i;
      upd_ready_s = ~swap_fire_s;
    end else begin
      swap_fire_s = 1'b0;
      upd_ready_s = 1'b0;
    end
  end

  // Next-state, write-port and output-register logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    pending_d = pending_q;
    instr_d   = instr_q;
    ivalid_d  = 1'b0;
    upd_err_d = 1'b0;
    par_err_d = 1'b0;
    we0_s     = 1'b0;
    we1_s     = 1'b0;
    wa0_s     = cnt_q[IDXW-1:0];
    wa1_s     = upd_addr_i[IDXW-1:0];
    wd0_s     = store_word(rom_word_s);
    wd1_s     = store_word(upd_data_i);
    case (state_q)
      ST_INIT: begin
        we0_s = 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_RUN: begin
        if (ivalid_i) begin
          ivalid_d = 1'b1;
          if (!iaddr_ok_s) begin
            instr_d = IW'(SV_IM_END_INSTR);
          end else if (par_bad_s) begin
            instr_d   = IW'(SV_IM_END_INSTR);
            par_err_d = 1'b1;
          end else begin
            instr_d = rd_word_s[IW-1:0];
          end
        end else begin
          ivalid_d = 1'b0;
        end

        // Updates always target the bank that is not being fetched from.
        if (upd_valid_i && upd_ready_s) begin
          if (!upd_ok_s) begin
            upd_err_d = 1'b1;
          end else if (active_q) begin
            we0_s = 1'b1;
            wa0_s = upd_addr_i[IDXW-1:0];
            wd0_s = store_word(upd_data_i);
          end else begin
            we1_s = 1'b1;
          end
        end else begin
          upd_err_d = 1'b0;
        end

        if (swap_fire_s) begin
          active_d  = ~active_q;
          pending_d = 1'b0;
        end else if (swap_req_i) begin
          pending_d = 1'b1;
        end else begin
          pending_d = pending_q;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      active_q  <= 1'b0;
      pending_q <= 1'b0;
      instr_q   <= IW'(SV_IM_END_INSTR);
      ivalid_q  <= 1'b0;
      upd_err_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      instr_q   <= instr_d;
      ivalid_q  <= ivalid_d;
      upd_err_q <= upd_err_d;
      par_err_q <= par_err_d;
    end
  end

  // Bank storage: no reset, bank 0 is rebuilt by the boot copy.
  always_ff @(posedge clk) begin
    if (we0_s) begin
      bank0_q[wa0_s] <= wd0_s;
    end
    if (we1_s) begin
      bank1_q[wa1_s] <= wd1_s;
    end
  end

  assign instr_o       = instr_q;
  assign ivalid_o      = ivalid_q;
  assign ready_o       = (state_q == ST_RUN);
  assign upd_ready_o   = upd_ready_s;
  assign upd_err_o     = upd_err_q;
  assign swap_ack_o    = swap_fire_s;
  assign active_bank_o = active_q;
  assign par_err_o     = par_err_q;

endmodule

// File: tb/tb_sv_im_banked.sv
// ---------------------------------------------------------------------------
// tb_sv_im_banked
// Directed bench for sv_im_banked: boot latency, fetch table, shadow load and
// swap, deferred swap, out-of-range update, mid-operation reset and, when
// SV_IM_PARITY_EN is defined, a corrupted stored word.
// ---------------------------------------------------------------------------
module tb_sv_im_banked;

  logic        clk;
  logic        areset;
  logic [7:0]  iaddr_i;
  logic        ivalid_i;
  logic [15:0] instr_o;
  logic        ivalid_o;
  logic        ready_o;
  logic        upd_valid_i;
  logic        upd_ready_o;
  logic [7:0]  upd_addr_i;
  logic [15:0] upd_data_i;
  logic        upd_err_o;
  logic        swap_req_i;
  logic        swap_ack_o;
  logic        active_bank_o;
  logic        par_err_o;

  int tests = 0;
  int fails = 0;

  sv_im_banked #(.IW(16), .AW(8), .DEPTH(128)) dut (
    .clk           (clk),
    .areset        (areset),
    .iaddr_i       (iaddr_i),
    .ivalid_i      (ivalid_i),
    .instr_o       (instr_o),
    .ivalid_o      (ivalid_o),
    .ready_o       (ready_o),
    .upd_valid_i   (upd_valid_i),
    .upd_ready_o   (upd_ready_o),
    .upd_addr_i    (upd_addr_i),
    .upd_data_i    (upd_data_i),
    .upd_err_o     (upd_err_o),
    .swap_req_i    (swap_req_i),
    .swap_ack_o    (swap_ack_o),
    .active_bank_o (active_bank_o),
    .par_err_o     (par_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        iv;
    logic [7:0]  addr;
    logic [15:0] exp_instr;
    logic        exp_iv;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ivalid_i    = 1'b0;
    iaddr_i     = 8'd0;
    upd_valid_i = 1'b0;
    upd_addr_i  = 8'd0;
    upd_data_i  = 16'h0000;
    swap_req_i  = 1'b0;
  endtask

  // Single fetch: drive, step one edge, return the registered result.
  task automatic fetch(input logic [7:0] a, input logic [15:0] exp, input string name);
    ivalid_i = 1'b1;
    iaddr_i  = a;
    tick();
    ivalid_i = 1'b0;
    check(name, {15'd0, ivalid_o}, 32'd1);
    check(name, {16'd0, instr_o}, {16'd0, exp});
  endtask

  // Count edges from reset release until ready_o; optionally poke the
  // fetch/update/swap inputs early in the copy (they must be ignored).
  task automatic boot(input logic inject, input string name);
    int  n;
    logic quiet_bad;
    n = 0;
    quiet_bad = 1'b0;
    while (ready_o !== 1'b1 && n < 400) begin
      if (inject && n < 4) begin
        swap_req_i  = 1'b1;
        ivalid_i    = 1'b1;
        iaddr_i     = 8'd0;
        upd_valid_i = 1'b1;
        upd_addr_i  = 8'd0;
        upd_data_i  = 16'hffff;
      end else begin
        idle_inputs();
      end
      #1;
      if (upd_ready_o !== 1'b0 || swap_ack_o !== 1'b0 || ivalid_o !== 1'b0) quiet_bad = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    idle_inputs();
    check(name, n, 32'd128);
    check("init_quiet", {31'd0, quiet_bad}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'd0,   16'h0011, 1'b1};
    vecs[1] = '{1'b1, 8'd5,   16'h3246, 1'b1};
    vecs[2] = '{1'b0, 8'd1,   16'h3246, 1'b0};
    vecs[3] = '{1'b1, 8'd82,  16'h0003, 1'b1};
    vecs[4] = '{1'b1, 8'd200, 16'h0003, 1'b1};
    vecs[5] = '{1'b1, 8'd1,   16'h0121, 1'b1};
    vecs[6] = '{1'b0, 8'd15,  16'h0121, 1'b0};
    vecs[7] = '{1'b1, 8'd127, 16'h0003, 1'b1};
    vecs[8] = '{1'b1, 8'd15,  16'h0902, 1'b1};

    areset = 1'b1;
    idle_inputs();
    repeat (3) tick();

    // Reset state
    check("rst_active", {31'd0, active_bank_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_upd_ready", {31'd0, upd_ready_o}, 32'd0);
    check("rst_ivalid", {31'd0, ivalid_o}, 32'd0);
    check("rst_swap_ack", {31'd0, swap_ack_o}, 32'd0);
    check("rst_upd_err", {31'd0, upd_err_o}, 32'd0);
    check("rst_par_err", {31'd0, par_err_o}, 32'd0);
    check("rst_instr", {16'd0, instr_o}, 32'h0003);

    // Boot copy with ignored inputs
    areset = 1'b0;
    boot(1'b1, "boot_latency");
    #1;
    check("boot_no_swap_ack", {31'd0, swap_ack_o}, 32'd0);
    check("boot_upd_ready", {31'd0, upd_ready_o}, 32'd1);
    tick();
    check("boot_no_swap", {31'd0, active_bank_o}, 32'd0);

    // Fetch table
    for (int i = 0; i < 9; i++) begin
      ivalid_i = vecs[i].iv;
      iaddr_i  = vecs[i].addr;
      tick();
      check($sformatf("vec%0d_instr", i), {16'd0, instr_o}, {16'd0, vecs[i].exp_instr});
      check($sformatf("vec%0d_ivalid", i), {31'd0, ivalid_o}, {31'd0, vecs[i].exp_iv});
      check($sformatf("vec%0d_par", i), {31'd0, par_err_o}, 32'd0);
    end
    idle_inputs();
    tick();

    // Shadow load while fetching, then swap
    upd_valid_i = 1'b1;
    upd_addr_i  = 8'd0;
    upd_data_i  = 16'h1234;
    ivalid_i    = 1'b1;
    iaddr_i     = 8'd0;
    #1;
    check("shadow_upd_ready", {31'd0, upd_ready_o}, 32'd1);
    tick();
    upd_valid_i = 1'b0;
    check("shadow_fetch_old", {16'd0, instr_o}, 32'h0011);
    for (int k = 0; k < 3; k++) begin
      ivalid_i = 1'b1;
      #1;
      check("shadow_no_ack", {31'd0, swap_ack_o}, 32'd0);
      tick();
      check("shadow_fetch_old", {16'd0, instr_o}, 32'h0011);
    end
    ivalid_i   = 1'b0;
    swap_req_i = 1'b1;
    #1;
    check("swap_ack", {31'd0, swap_ack_o}, 32'd1);
    check("swap_upd_ready", {31'd0, upd_ready_o}, 32'd0);
    tick();
    swap_req_i = 1'b0;
    check("swap_active", {31'd0, active_bank_o}, 32'd1);
    fetch(8'd0, 16'h1234, "swap_new_word");

    // Deferred swap: request while fetching for 10 cycles
    ivalid_i   = 1'b1;
    iaddr_i    = 8'd0;
    swap_req_i = 1'b1;
    #1;
    check("defer_ack0", {31'd0, swap_ack_o}, 32'd0);
    check("defer_upd_ready0", {31'd0, upd_ready_o}, 32'd1);
    tick();
    for (int k = 1; k < 10; k++) begin
      ivalid_i   = 1'b1;
      swap_req_i = (k == 3) ? 1'b1 : 1'b0;
      #1;
      check("defer_no_ack", {31'd0, swap_ack_o}, 32'd0);
      check("defer_upd_ready", {31'd0, upd_ready_o}, 32'd1);
      tick();
      check("defer_fetch", {16'd0, instr_o}, 32'h1234);
    end
    ivalid_i   = 1'b0;
    swap_req_i = 1'b0;
    #1;
    check("defer_ack", {31'd0, swap_ack_o}, 32'd1);
    check("defer_upd_closed", {31'd0, upd_ready_o}, 32'd0);
    tick();
    check("defer_active", {31'd0, active_bank_o}, 32'd0);
    check("defer_single_ack", {31'd0, swap_ack_o}, 32'd0);
    check("defer_upd_reopen", {31'd0, upd_ready_o}, 32'd1);
    tick();
    check("defer_single_swap", {31'd0, active_bank_o}, 32'd0);
    fetch(8'd0, 16'h0011, "defer_rom_word");

    // Good then out-of-range update into bank 1
    upd_valid_i = 1'b1;
    upd_addr_i  = 8'd2;
    upd_data_i  = 16'h5555;
    tick();
    check("upd_ok_no_err", {31'd0, upd_err_o}, 32'd0);
    upd_addr_i = 8'd130;
    upd_data_i = 16'hbeef;
    #1;
    check("bad_upd_ready", {31'd0, upd_ready_o}, 32'd1);
    tick();
    upd_valid_i = 1'b0;
    check("bad_upd_err", {31'd0, upd_err_o}, 32'd1);
    tick();
    check("bad_upd_err_pulse", {31'd0, upd_err_o}, 32'd0);
    fetch(8'd2, 16'h0231, "bad_upd_active_intact");
    swap_req_i = 1'b1;
    tick();
    swap_req_i = 1'b0;
    check("bad_upd_swap", {31'd0, active_bank_o}, 32'd1);
    fetch(8'd2, 16'h5555, "bad_upd_shadow_intact");
    fetch(8'd0, 16'h1234, "bank1_word0");

    // Reset with a swap pending
    ivalid_i   = 1'b1;
    iaddr_i    = 8'd0;
    swap_req_i = 1'b1;
    tick();
    swap_req_i = 1'b0;
    #1;
    check("midrst_pending_no_ack", {31'd0, swap_ack_o}, 32'd0);
    #1;
    areset = 1'b1;
    #1;
    check("midrst_active", {31'd0, active_bank_o}, 32'd0);
    check("midrst_ready", {31'd0, ready_o}, 32'd0);
    check("midrst_ack", {31'd0, swap_ack_o}, 32'd0);
    idle_inputs();
    tick();
    tick();
    areset = 1'b0;
    boot(1'b0, "reboot_latency");
    #1;
    check("reboot_no_ack", {31'd0, swap_ack_o}, 32'd0);
    tick();
    check("reboot_active", {31'd0, active_bank_o}, 32'd0);
    fetch(8'd5, 16'h3246, "reboot_rom_word");

`ifdef SV_IM_PARITY_EN
    // Corrupt one stored bit of bank 0 word 5
    dut.bank0_q[5][0] = ~dut.bank0_q[5][0];
    fetch(8'd5, 16'h0003, "par_bad_instr");
    check("par_bad_flag", {31'd0, par_err_o}, 32'd1);
    fetch(8'd0, 16'h0011, "par_good_instr");
    check("par_good_flag", {31'd0, par_err_o}, 32'd0);
`else
    check("par_tied0", {31'd0, par_err_o}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
